// File: rtl/uart_transceiver.sv
// uart_transceiver: full-duplex 8N1 UART, TX and RX sharing one programmable baud-tick generator.
// Define UART_FRAME_CHECK_EN to drop frames with a low stop bit and pulse rx_frame_err.
module uart_transceiver #(
  parameter int OVERSAMPLE = 24,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rstb,
  input  logic [7:0]           baudrate_cfg,
  input  logic                 rx,
  output logic                 tx,
  input  logic                 wr_en,
  input  logic [DATA_BITS-1:0] wr_data,
  output logic                 tx_busy,
  output logic                 rx_valid,
  output logic [DATA_BITS-1:0] rx_data
`ifdef UART_FRAME_CHECK_EN
  ,
  output logic                 rx_frame_err
`endif
);
  localparam int PW = $clog2(OVERSAMPLE + 1);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [PW-1:0] BIT_END   = PW'(OVERSAMPLE - 1);
  localparam logic [PW-1:0] HALF_END  = PW'(OVERSAMPLE / 2 - 1);
  localparam logic [PW-1:0] START_END = PW'(OVERSAMPLE);
  localparam logic [IW-1:0] LAST      = IW'(DATA_BITS - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  logic [7:0] cnt_q, cnt_d;
  logic tick;
  state_t tx_state_q, tx_state_d, rx_state_q, rx_state_d;
  logic [PW-1:0] tx_ph_q, tx_ph_d, rx_ph_q, rx_ph_d;
  logic [IW-1:0] tx_idx_q, tx_idx_d, rx_idx_q, rx_idx_d;
  logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
  logic tx_q, tx_d, rx_valid_q, rx_valid_d, err_q, err_d;
  logic [2:0] rx_sync_q, rx_sync_d;
  logic rx_bit, rx_fall;
  // >= rather than == so lowering the divider mid-count wraps at once
  assign tick    = cnt_q >= baudrate_cfg;
  assign cnt_d   = tick ? 8'd0 : cnt_q + 8'd1;
  assign rx_sync_d = {rx_sync_q[1:0], rx};
  assign rx_bit  = rx_sync_q[1];
  assign rx_fall = rx_sync_q[2] & ~rx_sync_q[1];
  assign tx       = tx_q;
  assign tx_busy  = tx_state_q != IDLE;
  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;
`ifdef UART_FRAME_CHECK_EN
  assign rx_frame_err = err_q;
`endif
  // Start bit spans the first tick after the latch plus a full bit of ticks
  always_comb begin
    tx_state_d = tx_state_q;
    tx_ph_d    = (tx_state_q != IDLE && tick) ? tx_ph_q + 1'b1 : tx_ph_q;
    tx_idx_d   = tx_idx_q;
    tx_sh_d    = tx_sh_q;
    case (tx_state_q)
      IDLE: if (wr_en) begin
        tx_state_d = START;
        tx_sh_d    = wr_data;
        tx_ph_d    = '0;
      end
      START: if (tick && tx_ph_q == START_END) begin
        tx_state_d = DATA;
        tx_ph_d    = '0;
        tx_idx_d   = '0;
      end
      DATA: if (tick && tx_ph_q == BIT_END) begin
        tx_ph_d    = '0;
        tx_sh_d    = tx_sh_q >> 1;
        tx_idx_d   = tx_idx_q + 1'b1;
        tx_state_d = tx_idx_q == LAST ? STOP : DATA;
      end
      default: if (tick && tx_ph_q == BIT_END) tx_state_d = IDLE;
    endcase
    tx_d = (tx_state_d == START) ? 1'b0 : (tx_state_d == DATA) ? tx_sh_d[0] : 1'b1;
  end
  always_comb begin
    rx_state_d = rx_state_q;
    rx_ph_d    = (rx_state_q != IDLE && tick) ? rx_ph_q + 1'b1 : rx_ph_q;
    rx_idx_d   = rx_idx_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    err_d      = 1'b0;
    case (rx_state_q)
      IDLE: if (rx_fall) begin
        rx_state_d = START;
        rx_ph_d    = '0;
      end
      START: if (tick && rx_ph_q == HALF_END) begin
        rx_state_d = rx_bit ? IDLE : DATA;
        rx_ph_d    = '0;
        rx_idx_d   = '0;
      end
      DATA: if (tick && rx_ph_q == BIT_END) begin
        rx_ph_d    = '0;
        rx_sh_d    = {rx_bit, rx_sh_q[DATA_BITS-1:1]};
        rx_idx_d   = rx_idx_q + 1'b1;
        rx_state_d = rx_idx_q == LAST ? STOP : DATA;
      end
      default: if (tick && rx_ph_q == BIT_END) begin
        rx_state_d = IDLE;
`ifdef UART_FRAME_CHECK_EN
        rx_data_d  = rx_bit ? rx_sh_q : rx_data_q;
        rx_valid_d = rx_bit;
        err_d      = ~rx_bit;
`else
        rx_data_d  = rx_sh_q;
        rx_valid_d = 1'b1;
`endif
      end
    endcase
  end
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      cnt_q      <= '0;
      tx_state_q <= IDLE;
      tx_ph_q    <= '0;
      tx_idx_q   <= '0;
      tx_sh_q    <= '0;
      tx_q       <= 1'b1;
      rx_sync_q  <= 3'b111;
      rx_state_q <= IDLE;
      rx_ph_q    <= '0;
      rx_idx_q   <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      tx_state_q <= tx_state_d;
      tx_ph_q    <= tx_ph_d;
      tx_idx_q   <= tx_idx_d;
      tx_sh_q    <= tx_sh_d;
      tx_q       <= tx_d;
      rx_sync_q  <= rx_sync_d;
      rx_state_q <= rx_state_d;
      rx_ph_q    <= rx_ph_d;
      rx_idx_q   <= rx_idx_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      err_q      <= err_d;
    end
  end
endmodule

// File: tb/tb_uart_transceiver.sv
// tb_uart_transceiver: directed checks of the UART transmitter, receiver, loopback and baud timing.
module tb_uart_transceiver;
  logic clk = 1'b0, rstb = 1'b0, wr_en = 1'b0, rx_drv = 1'b1, loop = 1'b0;
  logic [7:0] cfg = 8'd18, wr_data = 8'h00, rx_data;
  logic tx, tx_busy, rx_valid, rx, prev_valid = 1'b0;
  logic [7:0] got[$];
  int total = 0, bad = 0, dbl = 0, errs = 0;
  assign rx = loop ? tx : rx_drv;
  always #5 clk = ~clk;
`ifdef UART_FRAME_CHECK_EN
  logic rx_frame_err;
  always @(negedge clk) if (rx_frame_err) errs++;
`endif
  uart_transceiver dut (
    .clk(clk), .rstb(rstb), .baudrate_cfg(cfg), .rx(rx), .tx(tx),
    .wr_en(wr_en), .wr_data(wr_data), .tx_busy(tx_busy),
    .rx_valid(rx_valid), .rx_data(rx_data)
`ifdef UART_FRAME_CHECK_EN
    , .rx_frame_err(rx_frame_err)
`endif
  );
  always @(negedge clk) begin
    if (rx_valid) got.push_back(rx_data);
    if (rx_valid && prev_valid) dbl++;
    prev_valid = rx_valid;
  end
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic send(input logic [7:0] b);
    int n = 0;
    while (tx_busy && n < 20000) begin cyc(1); n++; end
    total++;
    if (tx_busy) begin bad++; $display("FAIL send_wait busy=%b exp=0", tx_busy); end
    wr_data = b; wr_en = 1'b1; cyc(1); wr_en = 1'b0;
  endtask
  task automatic wait_got(input int n, input int bound);
    int c = 0;
    while (got.size() < n && c < bound) begin cyc(1); c++; end
    total++;
    if (got.size() < n) begin bad++; $display("FAIL rx_wait got=%0d exp=%0d", got.size(), n); end
  endtask
  task automatic drive_frame(input logic [7:0] b, input logic stop, input int len);
    rx_drv = 1'b0; cyc(len);
    for (int i = 0; i < 8; i++) begin rx_drv = b[i]; cyc(len); end
    rx_drv = stop; cyc(len);
    rx_drv = 1'b1;
  endtask
  task automatic test_reset;
    cyc(10);
    total += 4;
    if (tx !== 1'b1) begin bad++; $display("FAIL rst_tx got=%b exp=1", tx); end
    if (tx_busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", tx_busy); end
    if (rx_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", rx_valid); end
    if (rx_data !== 8'h00) begin bad++; $display("FAIL rst_data got=%h exp=00", rx_data); end
    rstb = 1'b1; cyc(50);
    total += 3;
    if (tx !== 1'b1) begin bad++; $display("FAIL idle_tx got=%b exp=1", tx); end
    if (tx_busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b exp=0", tx_busy); end
    if (got.size() != 0) begin bad++; $display("FAIL idle_valid got=%0d exp=0", got.size()); end
  endtask
  task automatic test_tx_byte;
    logic [9:0] exp_bits = 10'b1_1010_0101_0;
    int l = 0;
    wr_data = 8'hA5; wr_en = 1'b1; cyc(1); wr_en = 1'b0;
    total += 2;
    if (tx_busy !== 1'b1) begin bad++; $display("FAIL tx_busy_rise got=%b exp=1", tx_busy); end
    if (tx !== 1'b0) begin bad++; $display("FAIL tx_start got=%b exp=0", tx); end
    while (tx === 1'b0 && l < 600) begin cyc(1); l++; end
    total++;
    if (l < 457 || l > 475) begin bad++; $display("FAIL tx_start_len got=%0d exp=457..475", l); end
    cyc(228);
    for (int i = 1; i < 10; i++) begin
      total++;
      if (tx !== exp_bits[i]) begin bad++; $display("FAIL tx_bit%0d got=%b exp=%b", i, tx, exp_bits[i]); end
      if (i < 9) cyc(456);
    end
    cyc(227);
    total += 2;
    if (tx_busy !== 1'b1) begin bad++; $display("FAIL tx_busy_hold got=%b exp=1", tx_busy); end
    cyc(1);
    if (tx_busy !== 1'b0) begin bad++; $display("FAIL tx_busy_fall got=%b exp=0", tx_busy); end
  endtask
  task automatic test_loopback;
    int base = got.size();
    loop = 1'b1; dbl = 0;
    send(8'h3C); send(8'hFF);
    wait_got(base + 2, 6000);
    total += 3;
    if (got.size() > base && got[base] !== 8'h3C) begin bad++; $display("FAIL lb_byte0 got=%h exp=3c", got[base]); end
    if (got.size() > base + 1 && got[base+1] !== 8'hFF) begin bad++; $display("FAIL lb_byte1 got=%h exp=ff", got[base+1]); end
    if (dbl != 0) begin bad++; $display("FAIL lb_pulse_width got=%0d exp=0", dbl); end
  endtask
  task automatic test_back_to_back_busy_write;
    int base;
    cyc(600);
    base = got.size();
    send(8'h12); cyc(1000);
    total++;
    if (tx_busy !== 1'b1) begin bad++; $display("FAIL bw_busy got=%b exp=1", tx_busy); end
    wr_data = 8'h55; wr_en = 1'b1; cyc(1); wr_en = 1'b0;
    wait_got(base + 1, 6000);
    cyc(1500);
    total += 4;
    if (got.size() > base && got[base] !== 8'h12) begin bad++; $display("FAIL bw_byte got=%h exp=12", got[base]); end
    if (got.size() != base + 1) begin bad++; $display("FAIL bw_count got=%0d exp=%0d", got.size(), base + 1); end
    if (tx_busy !== 1'b0) begin bad++; $display("FAIL bw_idle_busy got=%b exp=0", tx_busy); end
    if (tx !== 1'b1) begin bad++; $display("FAIL bw_idle_tx got=%b exp=1", tx); end
  endtask
  task automatic test_glitch;
    int base = got.size();
    loop = 1'b0; rx_drv = 1'b0; cyc(57); rx_drv = 1'b1; cyc(600);
    total++;
    if (got.size() != base) begin bad++; $display("FAIL glitch_valid got=%0d exp=%0d", got.size(), base); end
    drive_frame(8'h81, 1'b1, 456);
    cyc(10);
    total += 2;
    if (got.size() != base + 1) begin bad++; $display("FAIL glitch_next_count got=%0d exp=%0d", got.size(), base + 1); end
    if (rx_data !== 8'h81) begin bad++; $display("FAIL glitch_next_byte got=%h exp=81", rx_data); end
  endtask
  task automatic test_reset_midframe;
    int base = got.size();
    loop = 1'b1; send(8'h77); cyc(2000);
    rstb = 1'b0; #1;
    total += 3;
    if (tx !== 1'b1) begin bad++; $display("FAIL mid_rst_tx got=%b exp=1", tx); end
    if (tx_busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy got=%b exp=0", tx_busy); end
    if (rx_data !== 8'h00) begin bad++; $display("FAIL mid_rst_data got=%h exp=00", rx_data); end
    cyc(5); rstb = 1'b1; cyc(500);
    total++;
    if (got.size() != base) begin bad++; $display("FAIL mid_rst_valid got=%0d exp=%0d", got.size(), base); end
  endtask
  task automatic test_baud_change;
    int base = got.size(), l = 0;
    cfg = 8'd216; loop = 1'b1;
    send(8'h5A);
    while (tx === 1'b0 && l < 20000) begin cyc(1); l++; end
    l = 0;
    while (tx === 1'b1 && l < 10000) begin cyc(1); l++; end
    total++;
    if (l != 5208) begin bad++; $display("FAIL baud_bit_len got=%0d exp=5208", l); end
    wait_got(base + 1, 60000);
    total++;
    if (rx_data !== 8'h5A) begin bad++; $display("FAIL baud_byte got=%h exp=5a", rx_data); end
    cfg = 8'd18; loop = 1'b0; rx_drv = 1'b1; cyc(50);
  endtask
  task automatic test_stop_bit_low;
    int base = got.size(), e0 = errs;
    drive_frame(8'hC3, 1'b0, 456);
    cyc(50);
`ifdef UART_FRAME_CHECK_EN
    total += 3;
    if (got.size() != base) begin bad++; $display("FAIL ferr_valid got=%0d exp=%0d", got.size(), base); end
    if (errs - e0 != 1) begin bad++; $display("FAIL ferr_pulse got=%0d exp=1", errs - e0); end
    if (rx_data !== 8'h5A) begin bad++; $display("FAIL ferr_data got=%h exp=5a", rx_data); end
`else
    total += 3;
    if (got.size() != base + 1) begin bad++; $display("FAIL stop0_count got=%0d exp=%0d", got.size(), base + 1); end
    if (rx_data !== 8'hC3) begin bad++; $display("FAIL stop0_byte got=%h exp=c3", rx_data); end
    if (errs != e0) begin bad++; $display("FAIL stop0_err got=%0d exp=%0d", errs, e0); end
`endif
  endtask
  initial begin
    test_reset;
    test_tx_byte;
    test_loopback;
    test_back_to_back_busy_write;
    test_glitch;
    test_reset_midframe;
    test_baud_change;
    test_stop_bit_low;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
